// File: rtl/rv_iopmp_check_arbiter.sv
// -----------------------------------------------------------------------------
// rv_iopmp_check_arbiter
//
// Purpose:
//   Shares one rv_iopmp transaction checker between NUM_REQ requesters (for
//   example the AXI AW and AR paths). Requests are granted round-robin, one at
//   a time. The granted request is presented to the checker for
//   CHECK_LATENCY+1 cycles, the allow result is captured on the last of those
//   cycles and handed back to the owner on a valid/ready response channel.
//
// Optional feature macro:
//   RV_IOPMP_ARB_DENY_CNT_EN - adds deny_cnt_o, a saturating 16-bit count of
//   denied responses delivered to requesters.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   req_valid_i/ready_o   per-requester check request / grant (one-hot or 0)
//   req_addr_i            packed addresses,    NUM_REQ*ADDR_WIDTH
//   req_num_bytes_i       packed byte counts,  NUM_REQ*NB_WIDTH
//   req_sid_i             packed source IDs,   NUM_REQ*SID_WIDTH
//   req_access_i          per-requester access type
//   rsp_valid_o/allow_o   per-requester result (one-hot or 0), 1 = allowed
//   rsp_ready_i           per-requester result accept
//   chk_en_o, chk_*_o     transaction fields towards the checker
//   chk_allow_i           checker verdict
//   deny_cnt_o            (optional) saturating deny counter
// -----------------------------------------------------------------------------

package rv_iopmp_pkg;
  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'b00,
    ACCESS_READ  = 2'b01,
    ACCESS_WRITE = 2'b10,
    ACCESS_EXEC  = 2'b11
  } access_t;
endpackage

module rv_iopmp_check_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned SID_WIDTH     = 1,
  parameter int unsigned NB_WIDTH      = 4,
  parameter int unsigned CHECK_LATENCY = 0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr_i,
  input  logic [NUM_REQ*NB_WIDTH-1:0]          req_num_bytes_i,
  input  logic [NUM_REQ*SID_WIDTH-1:0]         req_sid_i,
  input  rv_iopmp_pkg::access_t [NUM_REQ-1:0]  req_access_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [NUM_REQ-1:0]                   rsp_allow_o,
  input  logic [NUM_REQ-1:0]                   rsp_ready_i,
  output logic                                 chk_en_o,
  output logic [ADDR_WIDTH-1:0]                chk_addr_o,
  output logic [NB_WIDTH-1:0]                  chk_num_bytes_o,
  output logic [SID_WIDTH-1:0]                 chk_sid_o,
  output rv_iopmp_pkg::access_t                chk_access_o,
  input  logic                                 chk_allow_i
`ifdef RV_IOPMP_ARB_DENY_CNT_EN
  ,
  output logic [15:0]                          deny_cnt_o
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // (base + off) mod NUM_REQ, used to scan requesters starting at the pointer
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % int'(NUM_REQ));
  endfunction

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB_WIDTH-1:0]   nb_q, nb_d;
  logic [SID_WIDTH-1:0]  sid_q, sid_d;
  rv_iopmp_pkg::access_t acc_q, acc_d;
  logic                  allow_q, allow_d;
  logic                  chk_en_q, chk_en_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]    rsp_allow_q, rsp_allow_d;

  logic                  any_valid_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [IDX_W-1:0]      ptr_next_s;

  // Round-robin pick: scanning downwards makes the lowest offset from the pointer win
  always_comb begin
    any_valid_s = 1'b0;
    win_idx_s   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      any_valid_s = any_valid_s | req_valid_i[wrap_idx(ptr_q, i)];
      win_idx_s   = req_valid_i[wrap_idx(ptr_q, i)] ? wrap_idx(ptr_q, i) : win_idx_s;
    end
    ptr_next_s = wrap_idx(win_idx_s, 1);
  end

  // Next-state, field capture and combinational grant
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    nb_d        = nb_q;
    sid_d       = sid_q;
    acc_d       = acc_q;
    allow_d     = allow_q;
    req_ready_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          req_ready_o[win_idx_s] = 1'b1;
          owner_d = win_idx_s;
          addr_d  = req_addr_i[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          nb_d    = req_num_bytes_i[win_idx_s*NB_WIDTH +: NB_WIDTH];
          sid_d   = req_sid_i[win_idx_s*SID_WIDTH +: SID_WIDTH];
          acc_d   = req_access_i[win_idx_s];
          ptr_d   = ptr_next_s;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // chk_allow_i is only trusted on the last cycle of the check window
        if (cnt_q == CNT_W'(CHECK_LATENCY)) begin
          allow_d = chk_allow_i;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_CHECK;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register inputs decoded from the upcoming state so outputs are flopped
  always_comb begin
    chk_en_d    = (state_d == ST_CHECK);
    rsp_valid_d = '0;
    rsp_allow_d = '0;
    rsp_valid_d[owner_d] = (state_d == ST_RESP);
    rsp_allow_d[owner_d] = (state_d == ST_RESP) & allow_d;
  end

  // State, pointer, captured fields and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      nb_q        <= '0;
      sid_q       <= '0;
      acc_q       <= rv_iopmp_pkg::ACCESS_NONE;
      allow_q     <= 1'b0;
      chk_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_allow_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      nb_q        <= nb_d;
      sid_q       <= sid_d;
      acc_q       <= acc_d;
      allow_q     <= allow_d;
      chk_en_q    <= chk_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_allow_q <= rsp_allow_d;
    end
  end

  // Checker fields hold their last captured values while chk_en_o is low
  assign chk_en_o        = chk_en_q;
  assign chk_addr_o      = addr_q;
  assign chk_num_bytes_o = nb_q;
  assign chk_sid_o       = sid_q;
  assign chk_access_o    = acc_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_allow_o     = rsp_allow_q;

`ifdef RV_IOPMP_ARB_DENY_CNT_EN
  logic [15:0] deny_q, deny_d;

  // Count denied responses at the handshake, saturating at all-ones
  always_comb begin
    if ((state_q == ST_RESP) && rsp_ready_i[owner_q] && !allow_q && (deny_q != 16'hFFFF)) begin
      deny_d = deny_q + 16'd1;
    end else begin
      deny_d = deny_q;
    end
  end

  // Deny counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deny_q <= 16'd0;
    end else begin
      deny_q <= deny_d;
    end
  end

  assign deny_cnt_o = deny_q;
`endif

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Two arbiters (CHECK_LATENCY 0 and 3, NUM_REQ 2) driven side by side and
// compared every cycle against a transaction-level model of the arbiter.
module tb_rv_iopmp_check_arbiter;
  import rv_iopmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        valid     [2];
  logic [1:0]        ready     [2];
  logic [127:0]      addr      [2];
  logic [7:0]        nb        [2];
  logic [1:0]        sid       [2];
  access_t [1:0]     acc       [2];
  logic [1:0]        rsp_valid [2];
  logic [1:0]        rsp_allow [2];
  logic [1:0]        rsp_ready [2];
  logic              chk_en    [2];
  logic [63:0]       chk_addr  [2];
  logic [3:0]        chk_nb    [2];
  logic [0:0]        chk_sid   [2];
  access_t           chk_acc   [2];
  logic              chk_allow [2];
`ifdef RV_IOPMP_ARB_DENY_CNT_EN
  logic [15:0]       deny      [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv_iopmp_check_arbiter #(
      .NUM_REQ(2), .ADDR_WIDTH(64), .SID_WIDTH(1), .NB_WIDTH(4),
      .CHECK_LATENCY((g == 0) ? 0 : 3)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(valid[g]), .req_ready_o(ready[g]),
      .req_addr_i(addr[g]), .req_num_bytes_i(nb[g]), .req_sid_i(sid[g]),
      .req_access_i(acc[g]),
      .rsp_valid_o(rsp_valid[g]), .rsp_allow_o(rsp_allow[g]), .rsp_ready_i(rsp_ready[g]),
      .chk_en_o(chk_en[g]), .chk_addr_o(chk_addr[g]), .chk_num_bytes_o(chk_nb[g]),
      .chk_sid_o(chk_sid[g]), .chk_access_o(chk_acc[g]), .chk_allow_i(chk_allow[g])
`ifdef RV_IOPMP_ARB_DENY_CNT_EN
      , .deny_cnt_o(deny[g])
`endif
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A granted transaction occupies a fixed window: check cycles are 1..L+1
  // cycles after the grant, the response follows until the owner accepts it.
  int          cyc = 0;
  bit          m_busy   [2];
  int          m_gcyc   [2];
  int          m_owner  [2];
  int          m_ptr    [2];
  logic [63:0] m_addr   [2];
  logic [3:0]  m_nb     [2];
  logic        m_sid    [2];
  logic [1:0]  m_acc    [2];
  logic        m_allow  [2];
  logic [1:0]  m_last_gnt [2];
  int          m_deny   [2];

  always @(negedge clk) begin
    int lat, el, w;
    logic [1:0] e_ready, e_rv, e_ra;
    logic e_en;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 0 : 3;
      if (rst) begin
        m_busy[k] = 1'b0; m_ptr[k] = 0; m_owner[k] = 0; m_addr[k] = 64'd0;
        m_nb[k] = 4'd0; m_sid[k] = 1'b0; m_acc[k] = 2'd0; m_allow[k] = 1'b0;
        m_deny[k] = 0;
      end
      e_ready = 2'b00; e_rv = 2'b00; e_ra = 2'b00; e_en = 1'b0; w = -1; el = 0;
      if (!m_busy[k]) begin
        for (int i = 0; i < 2; i++)
          if (w < 0 && valid[k][(m_ptr[k] + i) % 2]) w = (m_ptr[k] + i) % 2;
        if (w >= 0) e_ready[w] = 1'b1;
      end else begin
        el = cyc - m_gcyc[k];
        if (el <= lat + 1) e_en = 1'b1;
        else begin
          e_rv[m_owner[k]] = 1'b1;
          e_ra[m_owner[k]] = m_allow[k];
        end
      end
      check("req_ready", k, 64'(ready[k]), 64'(e_ready));
      check("chk_en", k, 64'(chk_en[k]), 64'(e_en));
      check("rsp_valid", k, 64'(rsp_valid[k]), 64'(e_rv));
      check("rsp_allow", k, 64'(rsp_allow[k]), 64'(e_ra));
      check("chk_addr", k, chk_addr[k], m_addr[k]);
      check("chk_nb", k, 64'(chk_nb[k]), 64'(m_nb[k]));
      check("chk_sid", k, 64'(chk_sid[k]), 64'(m_sid[k]));
      check("chk_access", k, 64'(chk_acc[k]), 64'(m_acc[k]));
`ifdef RV_IOPMP_ARB_DENY_CNT_EN
      check("deny_cnt", k, 64'(deny[k]), 64'(m_deny[k]));
`endif
      m_last_gnt[k] = 2'b00;
      if (!rst) begin
        if (!m_busy[k]) begin
          if (w >= 0) begin
            m_busy[k] = 1'b1; m_gcyc[k] = cyc; m_owner[k] = w;
            m_addr[k] = addr[k][w*64 +: 64]; m_nb[k] = nb[k][w*4 +: 4];
            m_sid[k] = sid[k][w]; m_acc[k] = acc[k][w];
            m_ptr[k] = (w + 1) % 2; m_last_gnt[k][w] = 1'b1;
          end
        end else if (el == lat + 1) begin
          m_allow[k] = chk_allow[k];
        end else if (el > lat + 1 && rsp_ready[k][m_owner[k]]) begin
          m_busy[k] = 1'b0;
          if (!m_allow[k] && m_deny[k] < 65535) m_deny[k]++;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(input int k, input int j);
    addr[k][j*64 +: 64] = {$urandom, $urandom};
    nb[k][j*4 +: 4]     = 4'($urandom);
    sid[k][j]           = 1'($urandom);
    acc[k][j]           = access_t'($urandom_range(0, 3));
  endtask

  int en_cnt, bp [2], n_gnt [2], order [2][4], budget;

  initial begin
    for (int k = 0; k < 2; k++) begin
      valid[k] = 2'b00; addr[k] = 128'd0; nb[k] = 8'd0; sid[k] = 2'b00;
      acc[k] = {ACCESS_NONE, ACCESS_NONE}; rsp_ready[k] = 2'b00; chk_allow[k] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request on port 0, then latency-3 allow timing on dut1
    for (int k = 0; k < 2; k++) begin
      valid[k] = 2'b01; addr[k] = {64'd0, 64'h8000_1000}; nb[k] = 8'h04;
      acc[k] = {ACCESS_NONE, ACCESS_READ}; rsp_ready[k] = 2'b01;
    end
    chk_allow[0] = 1'b1; chk_allow[1] = 1'b0; en_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (chk_en[1]) en_cnt++;
      case (c)
        0: begin check("lit_grant0", 0, 64'(ready[0]), 64'h1); check("lit_grant0", 1, 64'(ready[1]), 64'h1); end
        1: begin
          check("lit_en", 0, 64'(chk_en[0]), 64'h1); check("lit_addr", 0, chk_addr[0], 64'h8000_1000);
          check("lit_en", 1, 64'(chk_en[1]), 64'h1); check("lit_addr", 1, chk_addr[1], 64'h8000_1000);
        end
        2: begin check("lit_rspv", 0, 64'(rsp_valid[0]), 64'h1); check("lit_rspa", 0, 64'(rsp_allow[0]), 64'h1); end
        5: begin check("lit_rspv", 1, 64'(rsp_valid[1]), 64'h1); check("lit_rspa", 1, 64'(rsp_allow[1]), 64'h1); end
        default: ;
      endcase
      next_cycle();
      for (int k = 0; k < 2; k++) if (m_last_gnt[k][0]) valid[k] = 2'b00;
      chk_allow[1] = (c + 1 == 4);
    end
    check("lit_en_cycles", 1, 64'(en_cnt), 64'd4);

    // Reset asserted in the middle of a CHECK cycle
    for (int k = 0; k < 2; k++) begin valid[k] = 2'b10; rsp_ready[k] = 2'b00; end
    @(negedge clk);
    check("lit_grant1", 0, 64'(ready[0]), 64'h2); check("lit_grant1", 1, 64'(ready[1]), 64'h2);
    next_cycle();
    for (int k = 0; k < 2; k++) valid[k] = 2'b00;
    #2 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("lit_rst_en", k, 64'(chk_en[k]), 64'h0); check("lit_rst_rspv", k, 64'(rsp_valid[k]), 64'h0);
    end
    next_cycle();
    rst = 1'b0;

    // Round-robin with both ports requesting continuously
    for (int k = 0; k < 2; k++) begin valid[k] = 2'b11; rsp_ready[k] = 2'b11; n_gnt[k] = 0; end
    budget = 0;
    while ((n_gnt[0] < 4 || n_gnt[1] < 4) && budget < 80) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (ready[k] != 2'b00 && n_gnt[k] < 4) begin
          order[k][n_gnt[k]] = ready[k][1] ? 1 : 0;
          n_gnt[k]++;
        end
      next_cycle();
      budget++;
    end
    for (int k = 0; k < 2; k++) begin
      check("rr_grants", k, 64'(n_gnt[k]), 64'd4);
      for (int i = 0; i < n_gnt[k]; i++) check("rr_order", k, 64'(order[k][i]), 64'(i % 2));
    end
    for (int k = 0; k < 2; k++) valid[k] = 2'b00;
    repeat (12) next_cycle();

    // Response backpressure; ready on the wrong port must be ignored
    for (int k = 0; k < 2; k++) begin valid[k] = 2'b01; rsp_ready[k] = 2'b10; bp[k] = 0; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (rsp_valid[k] != 2'b00) begin
          bp[k]++;
          check("bp_rspv", k, 64'(rsp_valid[k]), 64'h1);
          check("bp_ready", k, 64'(ready[k]), 64'h0);
          check("bp_en", k, 64'(chk_en[k]), 64'h0);
        end
      next_cycle();
      for (int k = 0; k < 2; k++) if (m_last_gnt[k][0]) valid[k] = 2'b10;
    end
    for (int k = 0; k < 2; k++) check("bp_held", k, 64'(bp[k] >= 5), 64'h1);
    for (int k = 0; k < 2; k++) rsp_ready[k] = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("bp_last", k, 64'(rsp_valid[k]), 64'h1);
    next_cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("bp_release", k, 64'(rsp_valid[k]), 64'h0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin valid[k] = 2'b00; rsp_ready[k] = 2'b11; end
    repeat (12) next_cycle();

    // Randomized traffic; requesters hold fields until granted
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 2; j++) begin
          if (m_last_gnt[k][j] || !valid[k][j]) begin
            valid[k][j] = ($urandom_range(0, 2) == 0);
            if (valid[k][j]) rand_fields(k, j);
          end else if ($urandom_range(0, 31) == 0) begin
            valid[k][j] = 1'b0;
          end
        end
        chk_allow[k] = 1'($urandom);
        rsp_ready[k] = 2'($urandom);
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_iopmp_check_arbiter.md
Name: rv_iopmp_check_arbiter

Overview:
Shares one rv_iopmp_transaction_logic checker between NUM_REQ requesters, for example the AXI AW and AR paths of the data abstractor. Arbitrates round-robin and issues one check at a time to the checker. Samples the allow result after a fixed CHECK_LATENCY and returns it to the granted requester over a valid/ready response channel. Sits between the data abstractor(s) and the checker, inside the top-level IOPMP.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
ADDR_WIDTH, 64, address width
SID_WIDTH, 1, source-ID width
NB_WIDTH, 4, num_bytes width ($clog2(DATA_WIDTH/8)+1)
CHECK_LATENCY, 0, cycles from chk_en_o assertion to a valid chk_allow_i (0..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
req_valid_i  in  NUM_REQ  per-requester check request
req_ready_o  out  NUM_REQ  grant/accept, one-hot or zero
req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed request addresses
req_num_bytes_i  in  NUM_REQ*NB_WIDTH  packed byte counts
req_sid_i  in  NUM_REQ*SID_WIDTH  packed SIDs
req_access_i  in  NUM_REQ x rv_iopmp_pkg::access_t  access types
rsp_valid_o  out  NUM_REQ  result valid, one-hot or zero
rsp_allow_o  out  NUM_REQ  result: 1 = allowed
rsp_ready_i  in  NUM_REQ  result accepted
chk_en_o  out  1  to checker transaction_en
chk_addr_o  out  ADDR_WIDTH  to checker
chk_num_bytes_o  out  NB_WIDTH  to checker
chk_sid_o  out  SID_WIDTH  to checker
chk_access_o  out  access_t  to checker
chk_allow_i  in  1  checker allow_transaction

Behaviour:
- States: IDLE, CHECK, RESP.
- Reset (async, rst_i=1): state=IDLE, priority pointer=0, latency counter=0, all outputs 0, field registers 0. Reset during CHECK or RESP drops the pending check or response without emitting it.
- IDLE:
  - req_ready_o is combinational. If any req_valid_i is set, the winner is the first set bit at or after the pointer, wrapping from NUM_REQ-1 to 0. req_ready_o[winner]=1 in the same cycle.
  - On that edge: latch the winner's fields and owner index; pointer <= (winner+1) mod NUM_REQ; counter <= 0; go to CHECK.
  - If no request is valid, nothing changes.
- CHECK:
  - chk_en_o=1 and chk_* driven from the latched registers for the entire state. req_ready_o=0.
  - When counter == CHECK_LATENCY, register chk_allow_i into allow_q and go to RESP. Otherwise counter++.
  - Time in CHECK is CHECK_LATENCY+1 cycles.
- RESP:
  - chk_en_o=0. rsp_valid_o[owner]=1 and rsp_allow_o[owner]=allow_q. All other bits are 0.
  - Hold until rsp_ready_i[owner]=1, then go to IDLE. rsp_ready_i bits for non-owners are ignored.
- Outputs in IDLE: chk_en_o=0, rsp_* = 0.
- chk_* data outputs keep their last latched values when chk_en_o=0 (no forced zero).
- Throughput: one check per CHECK_LATENCY+3 cycles minimum. No back-to-back grant in a RESP->IDLE cycle; the grant occurs in the IDLE cycle itself.
- Requesters must hold valid and fields stable until ready (AXI-style). A requester that drops valid before its grant is simply not granted.
- Simultaneous requests are resolved by the pointer only. A continuously requesting port waits at most NUM_REQ-1 grants.
- NUM_REQ=1: the pointer is constant 0.

Optional Feature:
Macro RV_IOPMP_ARB_DENY_CNT_EN.
- Defined: adds output deny_cnt_o [15:0]. Increments by 1 on each RESP->IDLE handshake with allow_q=0. Saturates at 16'hFFFF. Reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_i pulsed mid-CHECK -> next cycle chk_en_o=0, rsp_valid_o=0, state IDLE. First grant after reset goes to requester 0 when both requesters are valid.
- Single request, CHECK_LATENCY=0: req_valid_i=01, addr=0x8000_1000, chk_allow_i=1 -> req_ready_o=01 in cycle 0; chk_en_o=1 with chk_addr_o=0x8000_1000 in cycle 1; rsp_valid_o=01 and rsp_allow_o=01 in cycle 2.
- Round-robin: req_valid_i=11 held for 4 grants -> grant order 0,1,0,1.
- Latency: CHECK_LATENCY=3, chk_allow_i=0 for the first 3 CHECK cycles and 1 in the 4th -> chk_en_o high for 4 cycles; rsp_allow_o[owner]=1.
- Backpressure: rsp_ready_i=0 for 5 cycles during RESP -> rsp_valid_o held stable, req_ready_o=0, chk_en_o=0. Releases on rsp_ready_i[owner]=1; rsp_ready_i on the wrong port has no effect.
- RV_IOPMP_ARB_DENY_CNT_EN: 3 denied and 2 allowed checks -> deny_cnt_o=3. Preloaded to 16'hFFFF plus 1 deny -> stays 16'hFFFF.
